pu_mem_loader: RTL



---
 rtl/pu_mem_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pu_mem_loader.sv
// pu_mem_loader: feeds one PU memory port from load/readback commands.
// Define PU_MEM_LOADER_RD_EN to build the readback FIFO and READ/DRAIN path.
module pu_mem_loader #(
    parameter int memDataLen        = 16,
    parameter int numPuMemColumns   = 2,
    parameter int logNumPeMemColumn = 2,
    parameter int logMemNamespaces  = 2,
    parameter int logMaxCount       = 16,
    localparam int memDataLenIn = memDataLen * numPuMemColumns,
    localparam int memCtrlIn    = (logNumPeMemColumn + 1) * numPuMemColumns
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rd_wrt,
    input  logic [logMemNamespaces-1:0] cmd_data_type,
    input  logic [logMaxCount-1:0]      cmd_count,
    input  logic [memDataLenIn-1:0]     wr_data,
    input  logic                        wr_data_valid,
    output logic                        wr_data_ready,
    output logic [memDataLenIn-1:0]     rd_data,
    output logic                        rd_data_valid,
    input  logic                        rd_data_ready,
    output logic                        mem_rd_wrt,
    output logic [memCtrlIn-1:0]        ctrl_mem_in,
    output logic [logMemNamespaces-1:0] mem_data_type,
    output logic [memDataLenIn-1:0]     mem_data_input,
    input  logic [memDataLenIn-1:0]     mem_data_output,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = logNumPeMemColumn + 1;

`ifdef PU_MEM_LOADER_RD_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;
`else
    typedef enum logic {S_IDLE, S_WRITE} state_t;
`endif

    state_t                        state_q, state_d;
    logic [logMaxCount-1:0]        rem_q, rem_d;
    logic [logNumPeMemColumn-1:0]  pe_q, pe_d;
    logic [logMemNamespaces-1:0]   type_q, type_d;
    logic                          done_d;
    logic                          beat, issue, step;
    logic [memCtrlIn-1:0]          ctrl_d, ctrl_q;
    logic [memDataLenIn-1:0]       din_q;

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign wr_data_ready  = (state_q == S_WRITE);
    assign beat           = wr_data_ready & wr_data_valid;
    assign step           = beat | issue;
    assign ctrl_mem_in    = ctrl_q;
    assign mem_data_input = din_q;
    assign mem_data_type  = type_q;

`ifdef PU_MEM_LOADER_RD_EN
    logic [memDataLenIn-1:0] fifo_q [4];
    logic [1:0]              wp_q, rp_q;
    logic [2:0]              cnt_q, cnt_d, outs_q, outs_d;
    logic                    rq_q, cap_q, push, pop, rd_wrt_q;

    // Credit covers both queued beats and requests still in the PU pipe
    assign issue = (state_q == S_READ) & (rem_q != '0)
                 & (({1'b0, outs_q} + {1'b0, cnt_q}) < 4'd4);
    assign push   = cap_q;
    assign pop    = (cnt_q != 3'd0) & rd_data_ready;
    assign cnt_d  = cnt_q + {2'b0, push} - {2'b0, pop};
    assign outs_d = outs_q + {2'b0, issue} - {2'b0, push};

    assign rd_data_valid = (cnt_q != 3'd0);
    assign rd_data       = rd_data_valid ? fifo_q[rp_q] : '0;
    assign mem_rd_wrt    = rd_wrt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            outs_q   <= '0;
            rq_q     <= 1'b0;
            cap_q    <= 1'b0;
            rd_wrt_q <= 1'b0;
        end else begin
            rq_q   <= issue;
            cap_q  <= rq_q;
            cnt_q  <= cnt_d;
            outs_q <= outs_d;
            if (push) wp_q <= wp_q + 2'd1;
            if (pop) rp_q <= rp_q + 2'd1;
            if (issue) rd_wrt_q <= 1'b1;
            else if (beat) rd_wrt_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wp_q] <= mem_data_output;
    end
`else
    logic unused_rd;

    assign issue         = 1'b0;
    assign rd_data       = '0;
    assign rd_data_valid = 1'b0;
    assign mem_rd_wrt    = 1'b0;
    assign unused_rd     = ^{mem_data_output, rd_data_ready};
`endif

    always_comb begin
        ctrl_d = '0;
        if (step) begin
            for (int c = 0; c < numPuMemColumns; c++) begin
                ctrl_d[CW*c] = 1'b1;
                ctrl_d[CW*c+1 +: logNumPeMemColumn] = pe_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pe_d    = pe_q;
        type_d  = type_q;
        done_d  = 1'b0;
        if (step) begin
            rem_d = rem_q - logMaxCount'(1);
            pe_d  = pe_q + logNumPeMemColumn'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    type_d = cmd_data_type;
                    rem_d  = cmd_count;
                    pe_d   = '0;
                    if (cmd_count == '0) begin
                        done_d = 1'b1;
                    end else if (!cmd_rd_wrt) begin
                        state_d = S_WRITE;
                    end else begin
`ifdef PU_MEM_LOADER_RD_EN
                        state_d = S_READ;
`else
                        done_d = 1'b1;
`endif
                    end
                end
            end
            S_WRITE: begin
                if (beat && rem_q == logMaxCount'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef PU_MEM_LOADER_RD_EN
            S_READ: begin
                if (issue && rem_q == logMaxCount'(1)) state_d = S_DRAIN;
            end
            // Retire on the final pop so done lands the cycle after it
            S_DRAIN: begin
                if (outs_d == 3'd0 && cnt_d == 3'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            pe_q    <= '0;
            type_q  <= '0;
            done    <= 1'b0;
            ctrl_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pe_q    <= pe_d;
            type_q  <= type_d;
            done    <= done_d;
            ctrl_q  <= ctrl_d;
            if (beat) din_q <= wr_data;
        end
    end

endmodule
